// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to compute multiplies combinationally (IDLE -> DONE in one cycle).
module mdu_iter #(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [XLEN-1:0]      INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [ITER_BITS-1:0] LAST    = ITER_BITS'(XLEN - 1);

  state_e               state_q, state_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]      opb_q, opb_d;
  logic [2:0]           f3_q, f3_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [XLEN-1:0]      rd_data_q, rd_data_d;

  // Operand decode at acceptance
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_acc;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic            div_zero, div_ovf, special;

  assign is_div   = funct3_i[2];
  assign a_sgn    = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign b_sgn    = is_div ? ~funct3_i[0] : ~funct3_i[1];
  assign a_neg    = a_sgn & rs1_data_i[XLEN-1];
  assign b_neg    = b_sgn & rs2_data_i[XLEN-1];
  assign a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
  // Remainder follows the dividend; quotient and product follow the sign difference.
  assign neg_acc  = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div && (rs2_data_i == '0);
  assign div_ovf  = is_div && !funct3_i[0] && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
  assign special  = div_zero || div_ovf;
  assign special_res = div_zero ? (funct3_i[1] ? rs1_data_i : '1)
                                : (funct3_i[1] ? '0 : INT_MIN);

`ifdef MDU_FAST_MUL_EN
  logic [XLEN:0]     fm_a, fm_b;
  logic [2*XLEN-1:0] fm_p;
  logic [XLEN-1:0]   fast_res;

  assign fm_a     = {a_neg, rs1_data_i};
  assign fm_b     = {b_neg, rs2_data_i};
  assign fm_p     = {{(XLEN-1){fm_a[XLEN]}}, fm_a} * {{(XLEN-1){fm_b[XLEN]}}, fm_b};
  assign fast_res = (funct3_i[1:0] == 2'b00) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`endif

  // One iteration of shift-add multiply: acc = {partial high, remaining multiplier}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res  = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // One iteration of restoring divide: acc = {remainder, dividend/quotient}.
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   div_sel, div_res;

  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
  assign div_nxt  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_sel  = f3_q[1] ? div_nxt[2*XLEN-1:XLEN] : div_nxt[XLEN-1:0];
  assign div_res  = neg_q ? -div_sel : div_sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    f3_d      = f3_q;
    rd_addr_d = rd_addr_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          f3_d      = funct3_i;
          rd_addr_d = rd_addr_i;
          neg_d     = neg_acc;
          cnt_d     = '0;
          if (is_div) begin
            opb_d = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            if (special) begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              rd_data_d = special_res;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            state_d   = S_DONE;
            done_d    = 1'b1;
            rd_data_d = fast_res;
`else
            opb_d   = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_nxt : div_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            rd_data_d = (state_q == S_MUL) ? mul_res : div_res;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      f3_q      <= '0;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      f3_q      <= f3_d;
      rd_addr_q <= rd_addr_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  // A flush landing in DONE squashes the write-back pulse.
  assign busy_o    = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o    = done_q && !flush_i;
  assign rd_wren_o = done_o && (rd_addr_q != 5'd0);
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random bench for mdu_iter: scoreboard of expected write-backs, latency and busy checks.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1_data_i = 32'd0;
  logic [31:0] rs2_data_i = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  mdu_iter #(.XLEN(32), .ITER_BITS(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .rd_wren_o(rd_wren_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wren;
    int          lat;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_data = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb_i;
    sa = a;
    sb_i = b;
    if (!f3[2]) begin
      ea = (f3 == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
      eb = (f3[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return f3[1] ? a : 32'hFFFFFFFF;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : a;
    case (f3[1:0])
      2'b00:   return sa / sb_i;
      2'b01:   return a / b;
      2'b10:   return sa % sb_i;
      default: return a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data);
    exp_t e;
    logic special;
    special = f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
`ifdef MDU_FAST_MUL_EN
    if (!f3[2]) special = 1'b1;
`endif
    e.data = exp_data;
    e.addr = rd;
    e.wren = (rd != 5'd0);
    e.lat  = special ? 1 : 33;
    e.busy = special ? 0 : 32;
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    int   edges = 0;
    int   busy  = 0;
    exp_t e;
    while (!done_o && edges < 40) begin
      if (busy_o) busy++;
      @(posedge clk_i); #1;
      edges++;
    end
    e = sb.pop_front();
    check({tag, ".done"}, done_o, 1'b1);
    check({tag, ".data"}, rd_data_o, e.data);
    check({tag, ".addr"}, rd_addr_o, e.addr);
    check({tag, ".wren"}, rd_wren_o, e.wren);
    check({tag, ".lat"}, edges + 1, e.lat);
    check({tag, ".busy"}, busy, e.busy);
    last_data = e.data;
    @(posedge clk_i); #1;
    check({tag, ".pulse"}, done_o, 1'b0);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data);
    issue(f3, a, b, rd, exp_data);
    collect(tag);
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (done_o) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    #12;
    check("rst.busy", busy_o, 1'b0);
    check("rst.done", done_o, 1'b0);
    check("rst.wren", rd_wren_o, 1'b0);
    check("rst.addr", rd_addr_o, 5'd0);
    check("rst.data", rd_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    run("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd1, 32'hFFFFFFFD);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd2, 32'hFFFFFFFF);
    run("divu",   3'b101, 32'd100,      32'd7,        5'd3, 32'd14);
    run("remu",   3'b111, 32'd100,      32'd7,        5'd4, 32'd2);
    run("div0",   3'b100, 32'd9,        32'd0,        5'd9, 32'hFFFFFFFF);
    run("remu0",  3'b111, 32'd9,        32'd0,        5'd10, 32'd9);
    run("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
    run("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0);
    run("rd0",    3'b101, 32'd50,       32'd5,        5'd0, 32'd10);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      rrd = 5'($urandom_range(1, 31));
      run("rand", rf3, ra, rb, rrd, model(rf3, ra, rb));
    end

    // Flush mid-DIVU with an ignored second start while busy
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b101; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_addr_i = 5'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b000; rd_addr_i = 5'd10;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("ign.busy", busy_o, 1'b1);
    repeat (6) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush.busy", busy_o, 1'b0);
    check("flush.done", done_o, 1'b0);
    count_done(40, seen);
    check("flush.nodone", seen, 0);
    check("flush.hold", rd_data_o, last_data);
    run("postflush", 3'b100, 32'd1000, 32'hFFFFFFFD, 5'd13, 32'hFFFFFEB3);

    // Reset in the middle of a divide
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'hFFFF0000; rs2_data_i = 32'd7; rd_addr_i = 5'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mrst.busy", busy_o, 1'b0);
    check("mrst.done", done_o, 1'b0);
    check("mrst.wren", rd_wren_o, 1'b0);
    check("mrst.addr", rd_addr_o, 5'd0);
    check("mrst.data", rd_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    count_done(40, seen);
    check("mrst.nodone", seen, 0);
    run("postrst", 3'b000, 32'h1234, 32'h10, 5'd31, 32'h12340);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
